// File: rtl/std_seq_mem_d1_if.sv
// rtl/std_seq_mem_d1_if.sv - request/completion bus of the sequential-read memory
interface std_seq_mem_d1_if #(
  parameter int width    = 32,
  parameter int idx_size = 4
);
  logic [idx_size-1:0] addr0;
  logic                content_en;
  logic                write_en;
  logic [width-1:0]    write_data;
  logic [width-1:0]    read_data;
  logic                done;

  modport master (
    output addr0, content_en, write_en, write_data,
    input  read_data, done
  );

  modport slave (
    input  addr0, content_en, write_en, write_data,
    output read_data, done
  );
endinterface

// File: rtl/std_seq_mem_d1.sv
// rtl/std_seq_mem_d1.sv - single-port memory with registered reads and fixed completion latency
module std_seq_mem_d1 #(
  parameter int width    = 32,
  parameter int size     = 16,
  parameter int idx_size = 4,
  parameter int latency  = 1
) (
  input  logic              clk,
  input  logic              reset,
  std_seq_mem_d1_if.slave   bus
);

  // Size widened by one bit so that size == 2**idx_size still compares correctly.
  localparam logic [idx_size:0] SIZE_L = (idx_size + 1)'(size);

  logic [width-1:0] r_mem [size];

  logic             w_accept;
  logic             w_in_range;
  logic [width-1:0] w_rd_word;

  // Stage-0 contents: what the acceptance edge loads into the pipeline.
  logic             w_s0_valid;
  logic             w_s0_is_read;
  logic [width-1:0] w_s0_data;

  // Exit stage: the values the output registers load at the next edge.
  logic             w_exit_valid;
  logic             w_exit_is_read;
  logic [width-1:0] w_exit_data;

  logic             r_done;
  logic [width-1:0] r_read_data;

  // A request presented while reset is high is never accepted.
  assign w_accept   = bus.content_en & ~reset;
  assign w_in_range = ({1'b0, bus.addr0} < SIZE_L);
  assign w_rd_word  = w_in_range ? r_mem[bus.addr0] : '0;

  assign w_s0_valid   = w_accept;
  assign w_s0_is_read = ~bus.write_en;
  assign w_s0_data    = bus.write_en ? '0 : w_rd_word;

  // Array update at the acceptance edge; out-of-range writes are dropped, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && bus.write_en && w_in_range) begin
      r_mem[bus.addr0] <= bus.write_data;
    end
  end

  // The output registers form the last stage, so latency-1 intermediate stages remain.
  generate
    if (latency == 1) begin : g_no_chain
      assign w_exit_valid   = w_s0_valid;
      assign w_exit_is_read = w_s0_is_read;
      assign w_exit_data    = w_s0_data;
    end else begin : g_chain
      logic             r_valid   [latency-1];
      logic             r_is_read [latency-1];
      logic [width-1:0] r_data    [latency-1];

      // Shift tokens one stage per cycle; reset kills every in-flight token.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < latency - 1; i++) begin
            r_valid[i] <= 1'b0;
          end
        end else begin
          r_valid[0] <= w_s0_valid;
          for (int i = 1; i < latency - 1; i++) begin
            r_valid[i] <= r_valid[i-1];
          end
        end
        r_is_read[0] <= w_s0_is_read;
        r_data[0]    <= w_s0_data;
        for (int i = 1; i < latency - 1; i++) begin
          r_is_read[i] <= r_is_read[i-1];
          r_data[i]    <= r_data[i-1];
        end
      end

      assign w_exit_valid   = r_valid[latency-2];
      assign w_exit_is_read = r_is_read[latency-2];
      assign w_exit_data    = r_data[latency-2];
    end
  endgenerate

  // Completion pulse per token; read_data only reloads on read completions and holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done      <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_done <= w_exit_valid;
      if (w_exit_valid && w_exit_is_read) begin
        r_read_data <= w_exit_data;
      end
    end
  end

  assign bus.done      = r_done;
  assign bus.read_data = r_read_data;

endmodule

// File: tb/tb_std_seq_mem_d1.sv
// tb/tb_std_seq_mem_d1.sv - directed testbench for std_seq_mem_d1 at several latencies and sizes
module tb_std_seq_mem_d1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l1, rst_l3, rst_l4, rst_oor;

  // Shared stimulus fanned out to every instance; each test checks only its own instance.
  logic [3:0]  s_addr;
  logic        s_en;
  logic        s_we;
  logic [31:0] s_wdata;

  std_seq_mem_d1_if #(.width(32), .idx_size(4)) if_l1 ();
  std_seq_mem_d1_if #(.width(32), .idx_size(4)) if_l3 ();
  std_seq_mem_d1_if #(.width(32), .idx_size(4)) if_l4 ();
  std_seq_mem_d1_if #(.width(32), .idx_size(4)) if_oor ();

  assign if_l1.addr0       = s_addr;
  assign if_l1.content_en  = s_en;
  assign if_l1.write_en    = s_we;
  assign if_l1.write_data  = s_wdata;
  assign if_l3.addr0       = s_addr;
  assign if_l3.content_en  = s_en;
  assign if_l3.write_en    = s_we;
  assign if_l3.write_data  = s_wdata;
  assign if_l4.addr0       = s_addr;
  assign if_l4.content_en  = s_en;
  assign if_l4.write_en    = s_we;
  assign if_l4.write_data  = s_wdata;
  assign if_oor.addr0      = s_addr;
  assign if_oor.content_en = s_en;
  assign if_oor.write_en   = s_we;
  assign if_oor.write_data = s_wdata;

  std_seq_mem_d1 #(.width(32), .size(16), .idx_size(4), .latency(1)) u_l1 (
    .clk(clk), .reset(rst_l1), .bus(if_l1));
  std_seq_mem_d1 #(.width(32), .size(16), .idx_size(4), .latency(3)) u_l3 (
    .clk(clk), .reset(rst_l3), .bus(if_l3));
  std_seq_mem_d1 #(.width(32), .size(16), .idx_size(4), .latency(4)) u_l4 (
    .clk(clk), .reset(rst_l4), .bus(if_l4));
  std_seq_mem_d1 #(.width(32), .size(10), .idx_size(4), .latency(1)) u_oor (
    .clk(clk), .reset(rst_oor), .bus(if_oor));

  int vectors     = 0;
  int miscompares = 0;

  localparam int OP_IDLE  = 0;
  localparam int OP_WRITE = 1;
  localparam int OP_READ  = 2;
  localparam int OP_GHOST = 3;

  // Each cycle begins 1 time unit after a rising edge: outputs are sampled and inputs driven there.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input logic [3:0] a, input logic [31:0] d);
    s_addr  = a;
    s_wdata = d;
    s_en    = (op == OP_WRITE) || (op == OP_READ);
    s_we    = (op == OP_WRITE) || (op == OP_GHOST);
  endtask

  task automatic test_reset;
    drive(OP_IDLE, 4'd0, 32'd0);
    rst_l1 = 1'b1; rst_l3 = 1'b1; rst_l4 = 1'b1; rst_oor = 1'b1;
    tick();
    tick();
    rst_l1 = 1'b0; rst_l3 = 1'b0; rst_l4 = 1'b0; rst_oor = 1'b0;
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (if_l1.done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_done c%0d: got %b expected 0", c, if_l1.done);
      end
      vectors++;
      if (if_l1.read_data !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rdata c%0d: got %h expected 00000000", c, if_l1.read_data);
      end
      vectors++;
      if (if_l4.done !== 1'b0 || if_l4.read_data !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_l4 c%0d: got done=%b rd=%h expected done=0 rd=00000000",
                 c, if_l4.done, if_l4.read_data);
      end
      tick();
    end
  endtask

  task automatic test_write_then_read;
    drive(OP_WRITE, 4'd3, 32'hDEADBEEF);
    tick();
    vectors++;
    if (if_l1.done !== 1'b1 || if_l1.read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL wr_done c1: got done=%b rd=%h expected done=1 rd=00000000",
               if_l1.done, if_l1.read_data);
    end
    drive(OP_READ, 4'd3, 32'h0);
    tick();
    vectors++;
    if (if_l1.done !== 1'b1 || if_l1.read_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rd_done c2: got done=%b rd=%h expected done=1 rd=deadbeef",
               if_l1.done, if_l1.read_data);
    end
    drive(OP_IDLE, 4'd0, 32'h0);
    for (int c = 3; c <= 10; c++) begin
      tick();
      vectors++;
      if (if_l1.done !== 1'b0 || if_l1.read_data !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL rd_hold c%0d: got done=%b rd=%h expected done=0 rd=deadbeef",
                 c, if_l1.done, if_l1.read_data);
      end
    end
  endtask

  task automatic test_write_only_completion;
    int          ops   [7] = '{OP_WRITE, OP_READ, OP_WRITE, OP_GHOST, OP_READ, OP_IDLE, OP_IDLE};
    logic [31:0] wd    [7] = '{32'h1234, 32'h0, 32'hAAAA, 32'hFFFF, 32'h0, 32'h0, 32'h0};
    logic        e_dn  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] e_rd  [7] = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h1234, 32'h1234,
                               32'h1234, 32'hAAAA, 32'hAAAA};
    for (int c = 0; c < 7; c++) begin
      vectors++;
      if (if_l1.done !== e_dn[c] || if_l1.read_data !== e_rd[c]) begin
        miscompares++;
        $display("FAIL write_only c%0d: got done=%b rd=%h expected done=%b rd=%h",
                 c, if_l1.done, if_l1.read_data, e_dn[c], e_rd[c]);
      end
      drive(ops[c], 4'd5, wd[c]);
      tick();
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 16; k++) begin
      drive(OP_WRITE, 4'(k), 32'(k * 32'h11));
      tick();
    end
    drive(OP_IDLE, 4'd0, 32'h0);
    repeat (5) tick();
    for (int c = 0; c <= 20; c++) begin
      logic        e_dn;
      logic [31:0] e_rd;
      int          last;
      e_dn = (c >= 3) && (c <= 18);
      vectors++;
      if (if_l3.done !== e_dn) begin
        miscompares++;
        $display("FAIL stream_done t+%0d: got %b expected %b", c, if_l3.done, e_dn);
      end
      if (c >= 3) begin
        last = (c > 18) ? 18 : c;
        e_rd = 32'((last - 3) * 32'h11);
        vectors++;
        if (if_l3.read_data !== e_rd) begin
          miscompares++;
          $display("FAIL stream_rdata t+%0d: got %h expected %h", c, if_l3.read_data, e_rd);
        end
      end
      if (c < 16) drive(OP_READ, 4'(c), 32'h0);
      else        drive(OP_IDLE, 4'd0, 32'h0);
      tick();
    end
  endtask

  task automatic test_reset_mid_flight;
    drive(OP_WRITE, 4'd1, 32'h01010101); tick();
    drive(OP_WRITE, 4'd2, 32'h02020202); tick();
    drive(OP_WRITE, 4'd3, 32'h03030303); tick();
    drive(OP_READ,  4'd1, 32'h0);        tick();
    drive(OP_IDLE,  4'd0, 32'h0);
    repeat (5) tick();
    vectors++;
    if (if_l4.read_data !== 32'h01010101) begin
      miscompares++;
      $display("FAIL mid_preread: got %h expected 01010101", if_l4.read_data);
    end
    for (int c = 0; c <= 15; c++) begin
      logic        e_dn;
      logic [31:0] e_rd;
      e_dn = (c == 13) || (c == 14);
      e_rd = (c <= 3) ? 32'h01010101 :
             (c <= 12) ? 32'h0 :
             (c == 13) ? 32'h01010101 : 32'h02020202;
      vectors++;
      if (if_l4.done !== e_dn || if_l4.read_data !== e_rd) begin
        miscompares++;
        $display("FAIL mid_flight c%0d: got done=%b rd=%h expected done=%b rd=%h",
                 c, if_l4.done, if_l4.read_data, e_dn, e_rd);
      end
      rst_l4 = (c == 3);
      case (c)
        0:       drive(OP_READ,  4'd1, 32'h0);
        1:       drive(OP_READ,  4'd2, 32'h0);
        2:       drive(OP_READ,  4'd3, 32'h0);
        3:       drive(OP_WRITE, 4'd1, 32'h00000BAD);
        9:       drive(OP_READ,  4'd1, 32'h0);
        10:      drive(OP_READ,  4'd2, 32'h0);
        default: drive(OP_IDLE,  4'd0, 32'h0);
      endcase
      tick();
    end
    rst_l4 = 1'b0;
  endtask

  task automatic test_out_of_range;
    int          ops  [7] = '{OP_WRITE, OP_READ, OP_WRITE, OP_READ, OP_READ, OP_IDLE, OP_IDLE};
    logic [3:0]  ad   [7] = '{4'd2, 4'd2, 4'd12, 4'd12, 4'd2, 4'd0, 4'd0};
    logic [31:0] wd   [7] = '{32'h22222222, 32'h0, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        e_dn [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] e_rd [7] = '{32'h0, 32'h0, 32'h22222222, 32'h22222222,
                              32'h0, 32'h22222222, 32'h22222222};
    drive(OP_IDLE, 4'd0, 32'h0);
    tick();
    for (int c = 0; c < 7; c++) begin
      vectors++;
      if (if_oor.done !== e_dn[c]) begin
        miscompares++;
        $display("FAIL oor_done c%0d: got %b expected %b", c, if_oor.done, e_dn[c]);
      end
      if (c >= 2) begin
        vectors++;
        if (if_oor.read_data !== e_rd[c]) begin
          miscompares++;
          $display("FAIL oor_rdata c%0d: got %h expected %h", c, if_oor.read_data, e_rd[c]);
        end
      end
      drive(ops[c], ad[c], wd[c]);
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_write_only_completion();
    test_back_to_back();
    test_reset_mid_flight();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
